// File: rtl/enigma_pkg.sv
// Shared constants and types for the Enigma console datapath.
// Used by uart_tx_queue (optionally built with UART_TX_QUEUE_GROUP_EN).
package enigma_pkg;

    localparam int UART_CLKS_PER_BIT = 10416;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_CR    = 8'd13;
    localparam logic [7:0] CHAR_LF    = 8'd10;
    localparam logic [7:0] CHAR_A     = 8'h41;
    localparam logic [7:0] CHAR_Z     = 8'h5A;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        WAIT_SP = 2'd2
    } tx_q_state_t;

    // Only upper-case letters take part in ciphertext grouping.
    function automatic logic is_upper_letter(input logic [7:0] b);
        return (b >= CHAR_A) && (b <= CHAR_Z);
    endfunction

endpackage

// File: rtl/uart_tx_queue_sync_fifo.sv
// Single-clock FIFO: storage, wrapping pointers, registered full/empty/count
// and a sticky overflow flag. DEPTH must be a power of two, at least 2.
module sync_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count,
    output logic             overflow
);

    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE_C   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] ZERO_C  = {(AW + 1){1'b0}};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             full_r;
    logic             empty_r;
    logic             overflow_r;

    logic             push_s;
    logic             pop_s;
    logic [AW:0]      count_nxt_s;

    // Accept/reject decisions use the registered flags, so a push while full
    // is refused even when a pop frees a slot on the same edge.
    always_comb begin
        push_s      = wr_en && !full_r;
        pop_s       = rd_en && !empty_r;
        count_nxt_s = count_r;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + ONE_C;
        end else if (!push_s && pop_s) begin
            count_nxt_s = count_r - ONE_C;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Byte storage; contents need no reset since empty guards every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers wrap naturally at the power-of-two boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= ZERO_C;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW - 1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW - 1){1'b0}}, 1'b1};
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == DEPTH_C);
            empty_r <= (count_nxt_s == ZERO_C);
            if (wr_en && full_r) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign rd_data  = mem_r[rd_ptr_r];
    assign full     = full_r;
    assign empty    = empty_r;
    assign count    = count_r;
    assign overflow = overflow_r;

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding uart_tx one frame at a time via tx_start/tx_done.
// Define UART_TX_QUEUE_GROUP_EN to insert a space after every GROUP_LEN letters.
module uart_tx_queue #(
    parameter int  DEPTH     = 16,
    parameter int  GROUP_LEN = 5,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count,
    output logic        overflow,
    input  logic        group_clr,
    input  logic        tx_active,
    input  logic        tx_done,
    output logic        tx_start,
    output logic [7:0]  tx_din
);

    import enigma_pkg::*;

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_WAIT    = WAIT;
    localparam logic [1:0] ST_WAIT_SP = WAIT_SP;

    logic [1:0] state_r;
    logic       tx_start_r;
    logic [7:0] tx_din_r;

    logic [7:0] head_s;
    logic       issue_s;
    logic       space_s;
    logic       pop_s;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (pop_s),
        .rd_data  (head_s),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

`ifdef UART_TX_QUEUE_GROUP_EN
    localparam int             GW       = $clog2(GROUP_LEN + 1);
    localparam logic [GW-1:0]  GRP_FULL = GW'(GROUP_LEN);

    logic [GW-1:0] grp_cnt_r;

    // Decide whether IDLE sends the head byte or a group-separating space.
    always_comb begin
        issue_s = 1'b0;
        space_s = 1'b0;
        pop_s   = 1'b0;
        if ((state_r == ST_IDLE) && !empty && !tx_active) begin
            issue_s = 1'b1;
            if ((grp_cnt_r == GRP_FULL) && is_upper_letter(head_s)) begin
                space_s = 1'b1;
            end else begin
                pop_s = 1'b1;
            end
        end else begin
            issue_s = 1'b0;
        end
    end

    // Letters issued since the last space, non-letter or external clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            grp_cnt_r <= {GW{1'b0}};
        end else if (group_clr || space_s) begin
            grp_cnt_r <= {GW{1'b0}};
        end else if (pop_s) begin
            grp_cnt_r <= is_upper_letter(head_s) ? (grp_cnt_r + {{(GW - 1){1'b0}}, 1'b1})
                                                 : {GW{1'b0}};
        end
    end
`else
    logic unused_s;
    assign unused_s = group_clr & (GROUP_LEN != 32'sd0);

    // Without grouping every issue is a pop of the head byte.
    always_comb begin
        space_s = 1'b0;
        if ((state_r == ST_IDLE) && !empty && !tx_active) begin
            issue_s = 1'b1;
            pop_s   = 1'b1;
        end else begin
            issue_s = 1'b0;
            pop_s   = 1'b0;
        end
    end
`endif

    // Sequencer: one frame in flight; tx_done is only honoured while waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            tx_start_r <= 1'b0;
            tx_din_r   <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (issue_s) begin
                        tx_start_r <= 1'b1;
                        tx_din_r   <= space_s ? CHAR_SPACE : head_s;
                        state_r    <= space_s ? ST_WAIT_SP : ST_WAIT;
                    end else begin
                        tx_start_r <= 1'b0;
                    end
                end
                ST_WAIT, ST_WAIT_SP: begin
                    tx_start_r <= 1'b0;
                    if (tx_done) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    tx_start_r <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_start = tx_start_r;
    assign tx_din   = tx_din_r;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue with a short-frame uart_tx stand-in.
module tb_uart_tx_queue;

    localparam int DEPTH     = 16;
    localparam int AW        = 4;
    localparam int GROUP_LEN = 5;
    localparam int FRAME_CYC = 4;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        wr_en     = 1'b0;
    logic [7:0]  wr_data   = 8'h00;
    logic        group_clr = 1'b0;
    logic        tx_active = 1'b0;
    logic        tx_done   = 1'b0;
    logic        full, empty, overflow, tx_start;
    logic [AW:0] count;
    logic [7:0]  tx_din;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    logic        hold_busy  = 1'b0;
    logic        force_done = 1'b0;
    int          busy_cnt   = 0;
    int          done_cnt   = 0;
    int          start_cnt  = 0;
    logic        frame_open = 1'b0;
    logic        prev_start = 1'b0;
    logic [7:0]  frame_byte = 8'h00;
`ifdef UART_TX_QUEUE_GROUP_EN
    int          m_grp = 0;
`endif

    uart_tx_queue #(.DEPTH(DEPTH), .GROUP_LEN(GROUP_LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .group_clr (group_clr),
        .tx_active (tx_active),
        .tx_done   (tx_done),
        .tx_start  (tx_start),
        .tx_din    (tx_din)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected uart_tx byte stream for one accepted push.
    task automatic enq(input logic [7:0] b);
`ifdef UART_TX_QUEUE_GROUP_EN
        if (b >= 8'h41 && b <= 8'h5A) begin
            if (m_grp == GROUP_LEN) begin
                exp_q.push_back(8'h20);
                m_grp = 0;
            end
            m_grp++;
        end else begin
            m_grp = 0;
        end
`endif
        exp_q.push_back(b);
    endtask

    task automatic push(input logic [7:0] b, input bit accept);
        wr_en   = 1'b1;
        wr_data = b;
        if (accept) enq(b);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || frame_open || !empty) && n < 3000) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL %s: drain timeout with %0d bytes pending, expected 0", name, exp_q.size());
        end
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL frame_done: got %0d frames, expected %0d", done_cnt, target);
        end
    endtask

    // Monitor (reads what the DUT saw this cycle) then uart_tx model update.
    initial begin
        int done_v;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                frame_open = 1'b0;
                prev_start = 1'b0;
            end else begin
                if (prev_start) chk("tx_start_width", {31'd0, tx_start}, 32'd0);
                if (tx_start) begin
                    start_cnt++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_tx_start: got tx_din %0h, expected no frame", tx_din);
                    end else begin
                        e = exp_q.pop_front();
                        if (tx_din !== e) begin
                            errors++;
                            $display("FAIL tx_din_order: got %0h, expected %0h", tx_din, e);
                        end
                    end
                    frame_open = 1'b1;
                    frame_byte = tx_din;
                end else if (tx_done && frame_open) begin
                    chk("tx_din_stable", {24'd0, tx_din}, {24'd0, frame_byte});
                    frame_open = 1'b0;
                    done_cnt++;
                end
                prev_start = tx_start;
            end
            done_v = 0;
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) done_v = 1;
            end else if (tx_start) begin
                busy_cnt = FRAME_CYC;
            end
            tx_active = hold_busy || (busy_cnt > 0);
            tx_done   = (done_v != 0) || force_done;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        string str;
        repeat (3) tick();
        chk("rst_count", {27'd0, count}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("rst_tx_din", {24'd0, tx_din}, 32'd0);
        rst = 1'b0;
        tick();

        // Single byte latency
        push(8'h41, 1'b1);
        chk("push_empty", {31'd0, empty}, 32'd0);
        chk("push_count", {27'd0, count}, 32'd1);
        tick();
        chk("issue_start", {31'd0, tx_start}, 32'd1);
        chk("issue_din", {24'd0, tx_din}, 32'h41);
        chk("issue_count", {27'd0, count}, 32'd0);
        tick();
        chk("issue_start_low", {31'd0, tx_start}, 32'd0);
        wait_idle("single");

        // Fill to full with uart_tx busy, then overflow
        hold_busy = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) push(8'h41 + 8'(i), 1'b1);
        chk("fill_full", {31'd0, full}, 32'd1);
        chk("fill_count", {27'd0, count}, 32'd16);
        chk("fill_overflow", {31'd0, overflow}, 32'd0);
        push(8'h51, 1'b0);
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        chk("ovf_count", {27'd0, count}, 32'd16);
        // push while full coinciding with the first pop is still rejected
        hold_busy = 1'b0;
        push(8'h52, 1'b0);
        chk("full_pop_count", {27'd0, count}, 32'd15);
        chk("full_pop_full", {31'd0, full}, 32'd0);
        wait_idle("full_drain");
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Steady occupancy of 5 across pointer wrap
        hold_busy = 1'b1;
        for (int i = 0; i < 5; i++) push(8'h21 + 8'(i), 1'b1);
        for (int i = 0; i < 14; i++) begin
            s = done_cnt;
            hold_busy = 1'b0;
            push(8'h26 + 8'(i), 1'b1);
            hold_busy = 1'b1;
            chk("wrap_count", {27'd0, count}, 32'd5);
            wait_done(s + 1);
        end
        hold_busy = 1'b0;
        wait_idle("wrap_drain");

        // tx_done while idle and empty
        s = start_cnt;
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        repeat (4) tick();
        chk("idle_done_no_start", s, start_cnt);
        chk("idle_done_empty", {31'd0, empty}, 32'd1);

        // Reset mid-frame with bytes pending
        push(8'h31, 1'b1);
        push(8'h32, 1'b0);
        push(8'h33, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
`ifdef UART_TX_QUEUE_GROUP_EN
        m_grp = 0;
`endif
        chk("mid_rst_count", {27'd0, count}, 32'd0);
        chk("mid_rst_empty", {31'd0, empty}, 32'd1);
        chk("mid_rst_overflow", {31'd0, overflow}, 32'd0);
        chk("mid_rst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("mid_rst_tx_din", {24'd0, tx_din}, 32'd0);
        s = start_cnt;
        repeat (12) tick();
        chk("late_done_no_start", s, start_cnt);

`ifdef UART_TX_QUEUE_GROUP_EN
        // Grouping: "ABCDEFG" CR "HIJKLM" -> "ABCDE FG" CR "HIJKL M"
        str = "ABCDEFG";
        for (int i = 0; i < str.len(); i++) push(str[i], 1'b1);
        push(8'd13, 1'b1);
        str = "HIJKLM";
        for (int i = 0; i < str.len(); i++) push(str[i], 1'b1);
        wait_idle("group_a");
        group_clr = 1'b1;
        tick();
        group_clr = 1'b0;
        m_grp = 0;
        str = "NOPQRST";
        for (int i = 0; i < str.len(); i++) push(str[i], 1'b1);
        wait_idle("group_clr");
`else
        str = "";
`endif

        push(8'h5A, 1'b1);
        wait_idle("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
